// File: rtl/gpcr_pkg.sv
// rtl/gpcr_pkg.sv - shared state encoding and level-count helper for the g/a/p carry resolver
package gpcr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMBINE = 2'd1,
        DONE    = 2'd2
    } gpcr_state_t;

    function automatic int GPCR_LEVELS(input int width);
        int l;
        l = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << l) < width) l = l + 1;
        end
        return l;
    endfunction

endpackage

// File: rtl/gp_combine.sv
// rtl/gp_combine.sv - prefix operator (g_hi,a_hi) o (g_lo,a_lo)
module gp_combine (
    input  logic g_hi_i,
    input  logic a_hi_i,
    input  logic g_lo_i,
    input  logic a_lo_i,
    output logic g_o,
    output logic a_o
);

    assign g_o = g_hi_i | (a_hi_i & g_lo_i);
    assign a_o = a_hi_i & a_lo_i;

endmodule

// File: rtl/gp_carry_resolver.sv
// rtl/gp_carry_resolver.sv - sequential Kogge-Stone carry resolver, one prefix level per clock
// Optional overflow output enabled by GPCR_OVERFLOW_EN.
module gp_carry_resolver
    import gpcr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] p_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             cout,
    output logic             busy
`ifdef GPCR_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int LEVELS = GPCR_LEVELS(WIDTH);
    localparam int LVL_W  = $clog2(LEVELS + 1);
    localparam int NSEL   = 1 << LVL_W;

    gpcr_state_t      state_q, state_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [WIDTH-1:0] g_q, g_d, a_q, a_d, p_q, p_d;
    logic             c0_q, c0_d;
    logic [WIDTH-1:0] sum_q, sum_d, carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] g_nxt, a_nxt;

    // Unused select slots (beyond LEVELS or i<d) feed the identity (g=0, a=1).
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [NSEL-1:0] lo_g, lo_a;
        for (genvar l = 0; l < NSEL; l++) begin : g_lvl
            if (l < LEVELS && i >= (1 << l)) begin : g_src
                assign lo_g[l] = g_q[i-(1<<l)];
                assign lo_a[l] = a_q[i-(1<<l)];
            end else begin : g_id
                assign lo_g[l] = 1'b0;
                assign lo_a[l] = 1'b1;
            end
        end
        gp_combine u_comb (
            .g_hi_i (g_q[i]),
            .a_hi_i (a_q[i]),
            .g_lo_i (lo_g[lvl_q]),
            .a_lo_i (lo_a[lvl_q]),
            .g_o    (g_nxt[i]),
            .a_o    (a_nxt[i])
        );
    end

`ifdef GPCR_OVERFLOW_EN
    logic ovf_q, ovf_d;
    assign ovf = ovf_q;
`endif

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        g_d     = g_q;
        a_d     = a_q;
        p_d     = p_q;
        c0_d    = c0_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef GPCR_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Folding cin into G[0] lets the prefix tree treat it as bit -1's generate.
                    g_d     = g_in;
                    g_d[0]  = g_in[0] | (a_in[0] & cin);
                    a_d     = a_in;
                    p_d     = p_in;
                    c0_d    = cin;
                    lvl_d   = '0;
                    state_d = COMBINE;
                end
            end
            COMBINE: begin
                g_d   = g_nxt;
                a_d   = a_nxt;
                lvl_d = lvl_q + 1'b1;
                if (lvl_q == LVL_W'(LEVELS - 1)) begin
                    carry_d = {g_nxt[WIDTH-2:0], c0_q};
                    sum_d   = p_q ^ carry_d;
                    cout_d  = g_nxt[WIDTH-1];
`ifdef GPCR_OVERFLOW_EN
                    ovf_d   = carry_d[WIDTH-1] ^ cout_d;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lvl_q   <= '0;
            g_q     <= '0;
            a_q     <= '0;
            p_q     <= '0;
            c0_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
            cout_q  <= 1'b0;
`ifdef GPCR_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            g_q     <= g_d;
            a_q     <= a_d;
            p_q     <= p_d;
            c0_q    <= c0_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef GPCR_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_gp_carry_resolver.sv
// tb/tb_gp_carry_resolver.sv - self-checking bench for gp_carry_resolver at WIDTH=8
module tb_gp_carry_resolver;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic [W-1:0] carry;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] g_in = '0, a_in = '0, p_in = '0;
    logic         in_ready, out_valid, cout, busy;
    logic [W-1:0] sum, carry;
`ifdef GPCR_OVERFLOW_EN
    logic         ovf;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gp_carry_resolver #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_in      (g_in),
        .a_in      (a_in),
        .p_in      (p_in),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .cout      (cout),
        .busy      (busy)
`ifdef GPCR_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition, carries recovered as sum ^ x ^ y.
    function automatic res_t model(input int x, input int y, input int c);
        res_t r;
        int   t, sx, sy, st;
        t       = x + y + c;
        r.sum   = t[W-1:0];
        r.cout  = (t >= (1 << W));
        r.carry = r.sum ^ x[W-1:0] ^ y[W-1:0];
        sx      = (x >= (1 << (W-1))) ? x - (1 << W) : x;
        sy      = (y >= (1 << (W-1))) ? y - (1 << W) : y;
        st      = sx + sy + c;
        r.ovf   = (st > (1 << (W-1)) - 1) || (st < -(1 << (W-1)));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        g_in = x & y;
        a_in = x | y;
        p_in = x ^ y;
        cin  = c;
    endtask

    task automatic check_result(input string tag, input int x, input int y, input int c);
        res_t r;
        r = model(x, y, c);
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_sum"}, sum, r.sum);
        check({tag, "_carry"}, carry, r.carry);
        check({tag, "_cout"}, cout, r.cout);
`ifdef GPCR_OVERFLOW_EN
        check({tag, "_ovf"}, ovf, r.ovf);
`endif
    endtask

    task automatic run_op(input string tag, input int x, input int y, input int c);
        int lat;
        drive(x[W-1:0], y[W-1:0], c[0]);
        in_valid = 1'b1;
        check({tag, "_in_ready_pre"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_in_ready_busy"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check_result(tag, x, y, c);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_hs_out_valid"}, out_valid, 0);
        check({tag, "_hs_in_ready"}, in_ready, 1);
    endtask

    res_t         exp_q[$];
    res_t         e;
    logic [W-1:0] cx, cy, held_sum, held_carry;
    logic         cc, held_cout, acc;
    int           cyc, last, n_acc, n_res, quiet;

    initial begin
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_carry", carry, 0);
        check("rst_cout", cout, 0);
        tick();
        rst = 1'b0;
        tick();

        run_op("t1", 8'h0F, 8'h01, 0);
        check("t1_sum_const", sum, 8'h10);
        check("t1_carry_const", carry, 8'h1E);
        handshake("t1");

        run_op("t2", 8'hFF, 8'h01, 0);
        handshake("t2");
        run_op("t3a", 8'h7F, 8'h01, 0);
        handshake("t3a");
        run_op("t3b", 8'hFF, 8'h00, 1);
        handshake("t3b");

        // Backpressure: result must hold while new bundles are offered and ignored.
        run_op("bp", 8'hA5, 8'h3C, 1);
        held_sum   = sum;
        held_carry = carry;
        held_cout  = cout;
        for (int k = 0; k < 10; k++) begin
            in_valid = ~in_valid;
            drive(W'($urandom), W'($urandom), 1'($urandom));
            tick();
            check("bp_sum", sum, held_sum);
            check("bp_carry", carry, held_carry);
            check("bp_cout", cout, held_cout);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        handshake("bp");
        tick();
        check("bp_no_second", out_valid, 0);
        check("bp_idle", busy, 0);

        // Reset while in COMBINE with lvl=1.
        drive(8'h55, 8'h66, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_in_ready", in_ready, 1);
        check("mr_busy", busy, 0);
        tick();
        rst = 1'b0;
        quiet = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid) quiet++;
        end
        check("mr_no_pulse", quiet, 0);
        check("mr_in_ready_after", in_ready, 1);
        run_op("mr_next", 8'h03, 8'h05, 0);
        check("mr_next_sum_const", sum, 8'h08);
        handshake("mr_next");

        // Back-to-back with in_valid and out_ready held high.
        cx = W'($urandom); cy = W'($urandom); cc = 1'($urandom);
        drive(cx, cy, cc);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0; last = -1; n_acc = 0; n_res = 0;
        while (n_res < 20 && cyc < 400) begin
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back(model(int'(cx), int'(cy), int'(cc)));
                if (last >= 0) check("b2b_spacing", cyc - last, 5);
                last = cyc;
                n_acc++;
            end
            if (out_valid && out_ready) begin
                check("b2b_have_expect", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("b2b_sum", sum, e.sum);
                    check("b2b_carry", carry, e.carry);
                    check("b2b_cout", cout, e.cout);
`ifdef GPCR_OVERFLOW_EN
                    check("b2b_ovf", ovf, e.ovf);
`endif
                end
                n_res++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (n_acc < 20) begin
                    cx = W'($urandom); cy = W'($urandom); cc = 1'($urandom);
                    drive(cx, cy, cc);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_results", n_res, 20);
        check("b2b_drained", exp_q.size(), 0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gp_carry_resolver.md
# gp_carry_resolver

Sequential parallel-prefix carry resolver for the prefix-adder datapath. It consumes the per-bit generate/alive/propagate vectors produced by the bitwise g/a/p cells and resolves all carries Kogge-Stone style, one prefix level per clock. It then emits the sum, the carry vector and the carry-out behind a valid/ready handshake. It is the consumer end of the g/a/p interface and trades latency for one shared row of prefix operators.

## Interface
- WIDTH, 32, operand width; power of two, ≥ 2
- LEVELS, $clog2(WIDTH), derived, not overridable; number of prefix levels
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  g/a/p/cin bundle valid
- in_ready  output  1  block can accept a bundle
- g_in  input  WIDTH  per-bit generate (x&y)
- a_in  input  WIDTH  per-bit alive (x|y)
- p_in  input  WIDTH  per-bit propagate (x^y)
- cin  input  1  carry into bit 0
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  p ^ carries
- carry  output  WIDTH  carry into each bit; carry[0]=cin
- cout  output  1  carry out of bit WIDTH-1
- busy  output  1  high in COMBINE or DONE

## Operation
- FSM states: IDLE, COMBINE, DONE; 2-bit state register; level counter lvl, $clog2(LEVELS+1) bits.
- IDLE: in_ready=1. On in_valid&in_ready: latch P=p_in, C0=cin, A=a_in, and G=g_in with G[0]=g_in[0]|(a_in[0]&cin); lvl=0; go to COMBINE.
- COMBINE: each edge applies level lvl with distance d=2^lvl. For i≥d: G[i]=G[i]|(A[i]&G[i-d]) and A[i]=A[i]&A[i-d]. For i<d: G[i] and A[i] are unchanged. lvl increments; after the level with lvl=LEVELS-1, go to DONE.
- DONE: outputs are registered on entry.
  - carry = {G[WIDTH-2:0], C0}
  - sum = P ^ carry
  - cout = G[WIDTH-1]
  - out_valid=1
- DONE exit: on out_valid&out_ready, clear out_valid and go to IDLE.
- in_ready is 0 in COMBINE and DONE. in_valid is ignored there and no bundle is queued.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0; sum, carry and cout are all 0; internal G/A/P/C0/lvl are all 0.
- Reset mid-operation (any state) discards the in-flight bundle. No out_valid pulse is produced for it.
- Arithmetic is modulo 2^WIDTH. cout carries the unsigned overflow.

## Timing
- Accept edge T. Levels are applied at edges T+1…T+LEVELS. out_valid is high after edge T+LEVELS (WIDTH=32: 5 cycles).
- Output handshake edge U: in_ready=1 from U. The earliest next accept is at U+1, so minimum throughput is one op per LEVELS+2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- in_ready and busy are decoded from the state register only.

## Configuration
- GPCR_OVERFLOW_EN: when defined, adds output port ovf (1 bit) = carry-into-MSB ^ cout, i.e. two's-complement overflow. It is registered with the other results and resets to 0.
- Without the macro, the ovf port and its logic are absent.

## Structure
- Package gpcr_pkg holds:
  - state enum gpcr_state_t {IDLE, COMBINE, DONE}
  - the GPCR_LEVELS helper function (clog2)
- One sub-module, gp_combine: the prefix operator (g_hi,a_hi)∘(g_lo,a_lo) → (g_hi|(a_hi&g_lo), a_hi&a_lo). It is instantiated WIDTH times in a generate loop with the lower operand muxed by lvl.

## Test plan
All scenarios use WIDTH=8 (LEVELS=3).
- x=0x0F, y=0x01, cin=0 (g=0x01, a=0x0F, p=0x0E) → sum=0x10, carry=0x1E, cout=0, out_valid exactly 3 cycles after accept.
- x=0xFF, y=0x01, cin=0 → sum=0x00, cout=1; with GPCR_OVERFLOW_EN, ovf=0.
- x=0x7F, y=0x01, cin=0 → sum=0x80, cout=0, ovf=1. Then x=0xFF, y=0x00, cin=1 → sum=0x00, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles while toggling in_valid with new data → sum/carry/cout stable, in_ready=0, no second result. Release → handshake, in_ready=1 next cycle.
- Assert rst for one cycle while in COMBINE at lvl=1 → out_valid stays 0 and in_ready=1 after release. The next bundle x=0x03, y=0x05 gives sum=0x08.
- Back-to-back: in_valid held high with out_ready=1 → accepts spaced LEVELS+2=5 cycles apart, and every result matches x+y+cin.
